// File: rtl/upsample_nearest_pkg.sv
// Shared types and constants for the nearest-neighbour up-sampling engine.
package upsample_nearest_pkg;

  localparam int MAX_ROW   = 64;
  localparam int MAX_SCALE = 4;

  localparam int ROW_W   = $clog2(MAX_ROW + 1);
  localparam int SCALE_W = 3;
  localparam int CH_W    = 16;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_PARAM,
    RUN,
    DRAIN,
    FINISH
  } upsample_state_t;

  localparam logic WRITE_ENB = 1'b1;
  localparam logic WRITE_DIS = 1'b0;

  localparam logic [ADDR_W-1:0] UPS_PARAM_ROW   = 32'd0;
  localparam logic [ADDR_W-1:0] UPS_PARAM_CH    = 32'd1;
  localparam logic [ADDR_W-1:0] UPS_PARAM_SCALE = 32'd2;

  // A zero scale means "no up-sampling"; anything above the supported maximum saturates.
  function automatic logic [SCALE_W-1:0] clamp_scale(input logic [SCALE_W-1:0] raw);
    if (raw == '0)
      return SCALE_W'(1);
    else if (raw > SCALE_W'(MAX_SCALE))
      return SCALE_W'(MAX_SCALE);
    else
      return raw;
  endfunction

endpackage

// File: rtl/sp_ram_intf.sv
// Single-port SRAM handshake shared by all EPU layer engines.
interface sp_ram_intf;
  logic        cs;
  logic [31:0] addr;
  logic        W_req;
  logic [31:0] W_data;
  logic        oe;
  logic [31:0] R_data;

  modport compute (output cs, addr, W_req, W_data, oe, input R_data);
  modport memory  (input cs, addr, W_req, W_data, oe, output R_data);
endinterface

// File: rtl/upsample_addr_gen.sv
// Walks (ch, oy, ox) in output order and keeps the matching input-pixel address
// incrementally, so no divider is needed to map an output pixel back to its source.
module upsample_addr_gen
  import upsample_nearest_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               clear,
  input  logic               step,
  input  logic [ROW_W-1:0]   row,
  input  logic [CH_W-1:0]    ch_num,
  input  logic [SCALE_W-1:0] scale,
  output logic [ADDR_W-1:0]  addr,
  output logic               last_pixel
);

  logic [SCALE_W-1:0] sx, sy;
  logic [ROW_W-1:0]   ix, iy;
  logic [CH_W-1:0]    ch;
  logic               sx_last, sy_last, ix_last, iy_last, ch_last;

  // Terminal-count flags for each nested counter.
  always_comb begin
    sx_last    = (sx == scale - SCALE_W'(1));
    sy_last    = (sy == scale - SCALE_W'(1));
    ix_last    = (ix == row - ROW_W'(1));
    iy_last    = (iy == row - ROW_W'(1));
    ch_last    = (ch == ch_num - CH_W'(1));
    last_pixel = sx_last & ix_last & sy_last & iy_last & ch_last;
  end

  // Advance one output pixel per step; end of an output row either rewinds to the
  // start of the same input row (more replicas left) or moves on to the next one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sx   <= '0;
      sy   <= '0;
      ix   <= '0;
      iy   <= '0;
      ch   <= '0;
      addr <= '0;
    end else if (clear) begin
      sx   <= '0;
      sy   <= '0;
      ix   <= '0;
      iy   <= '0;
      ch   <= '0;
      addr <= '0;
    end else if (step) begin
      if (!sx_last) begin
        sx <= sx + SCALE_W'(1);
      end else begin
        sx <= '0;
        if (!ix_last) begin
          ix   <= ix + ROW_W'(1);
          addr <= addr + ADDR_W'(1);
        end else begin
          ix <= '0;
          if (!sy_last) begin
            sy   <= sy + SCALE_W'(1);
            addr <= addr - ADDR_W'(row - ROW_W'(1));
          end else begin
            sy   <= '0;
            addr <= addr + ADDR_W'(1);
            if (!iy_last) begin
              iy <= iy + ROW_W'(1);
            end else begin
              iy <= '0;
              ch <= ch_last ? '0 : ch + CH_W'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/upsample_nearest.sv
// Nearest-neighbour up-sampling layer engine: loads R/C/S, then streams one output
// pixel per cycle, each a copy of its source input pixel.
module upsample_nearest
  import upsample_nearest_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        finish,
  sp_ram_intf.compute param_intf,
  sp_ram_intf.compute bias_intf,
  sp_ram_intf.compute weight_intf,
  sp_ram_intf.compute input_intf,
  sp_ram_intf.compute output_intf
);

  upsample_state_t    state, state_next;
  logic [1:0]         cnt;
  logic [ROW_W-1:0]   row_q;
  logic [CH_W-1:0]    ch_num_q;
  logic [SCALE_W-1:0] scale_q;
  logic [ADDR_W-1:0]  out_addr;
  logic               w_req_q;
  logic               last_pixel;
  logic               addr_clear;

  assign addr_clear = (state_next == FINISH);

  upsample_addr_gen u_addr_gen (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (addr_clear),
    .step       (state == RUN),
    .row        (row_q),
    .ch_num     (ch_num_q),
    .scale      (scale_q),
    .addr       (input_intf.addr),
    .last_pixel (last_pixel)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Parameter-load counter and parameter latches; R_data lags the address by one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      row_q    <= '0;
      ch_num_q <= '0;
      scale_q  <= '0;
    end else begin
      cnt <= (state == LOAD_PARAM) ? cnt + 2'd1 : 2'd0;
      if (state == LOAD_PARAM) begin
        case (cnt)
          2'd1:    row_q    <= param_intf.R_data[ROW_W-1:0];
          2'd2:    ch_num_q <= param_intf.R_data[CH_W-1:0];
          2'd3:    scale_q  <= clamp_scale(param_intf.R_data[SCALE_W-1:0]);
          default: ;
        endcase
      end
    end
  end

  // Next-state decode and per-state SRAM strobes.
  always_comb begin
    state_next      = state;
    finish          = 1'b0;
    param_intf.cs   = 1'b0;
    param_intf.addr = '0;
    input_intf.cs   = 1'b0;
    output_intf.cs  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD_PARAM;
      end
      LOAD_PARAM: begin
        param_intf.cs = 1'b1;
        case (cnt)
          2'd0:    param_intf.addr = UPS_PARAM_ROW;
          2'd1:    param_intf.addr = UPS_PARAM_CH;
          2'd2:    param_intf.addr = UPS_PARAM_SCALE;
          default: param_intf.addr = '0;
        endcase
        if (cnt == 2'd3)
          state_next = (row_q == '0 || ch_num_q == '0) ? FINISH : RUN;
      end
      RUN: begin
        input_intf.cs  = 1'b1;
        output_intf.cs = 1'b1;
        if (last_pixel) state_next = DRAIN;
      end
      DRAIN: begin
        output_intf.cs = 1'b1;
        state_next     = FINISH;
      end
      FINISH: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write strobe trails each read issue by one cycle; output address counts writes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_req_q  <= WRITE_DIS;
      out_addr <= '0;
    end else begin
      w_req_q <= (state == RUN) ? WRITE_ENB : WRITE_DIS;
      if (addr_clear)
        out_addr <= '0;
      else if (w_req_q == WRITE_ENB)
        out_addr <= out_addr + ADDR_W'(1);
    end
  end

  assign output_intf.addr   = out_addr;
  assign output_intf.W_req  = w_req_q;
  assign output_intf.W_data = {24'h0, input_intf.R_data[7:0]};
  assign output_intf.oe     = 1'b1;

  assign input_intf.W_req   = WRITE_DIS;
  assign input_intf.W_data  = '0;
  assign input_intf.oe      = 1'b1;

  assign param_intf.W_req   = WRITE_DIS;
  assign param_intf.W_data  = '0;
  assign param_intf.oe      = 1'b1;

  assign bias_intf.cs       = 1'b0;
  assign bias_intf.addr     = '0;
  assign bias_intf.W_req    = WRITE_DIS;
  assign bias_intf.W_data   = '0;
  assign bias_intf.oe       = 1'b1;

  assign weight_intf.cs     = 1'b0;
  assign weight_intf.addr   = '0;
  assign weight_intf.W_req  = WRITE_DIS;
  assign weight_intf.W_data = '0;
  assign weight_intf.oe     = 1'b1;

endmodule

// File: tb/tb_upsample_nearest.sv
// Directed bench: SRAM models around the engine, a reference model built from
// plain index arithmetic, and one per-cycle compare process.
module tb_upsample_nearest;

  logic clk = 1'b0;
  logic rstn;
  logic start;
  logic finish;

  always #5 clk = ~clk;

  sp_ram_intf param_if ();
  sp_ram_intf bias_if ();
  sp_ram_intf weight_if ();
  sp_ram_intf input_if ();
  sp_ram_intf output_if ();

  upsample_nearest dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .finish      (finish),
    .param_intf  (param_if),
    .bias_intf   (bias_if),
    .weight_intf (weight_if),
    .input_intf  (input_if),
    .output_intf (output_if)
  );

  logic [31:0] pmem [4];
  logic [7:0]  in_mem [256];
  int          out_mem [1024];

  // Synchronous-read SRAM models.
  always @(posedge clk) if (param_if.cs) param_if.R_data <= pmem[param_if.addr[1:0]];
  always @(posedge clk) if (input_if.cs) input_if.R_data <= {24'h0, in_mem[input_if.addr[7:0]]};
  assign bias_if.R_data   = 32'h0;
  assign weight_if.R_data = 32'h0;
  assign output_if.R_data = 32'h0;

  int total;
  int bad;

  int exp_q[$];
  int n_exp;
  int fin_rel;
  int rel;
  bit active;
  bit done;
  int wcount;
  int fin_lat;

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic check_reset();
    chk("rst_finish", finish, 0);
    chk("rst_out_cs", output_if.cs, 0);
    chk("rst_out_wreq", output_if.W_req, 0);
    chk("rst_out_addr", output_if.addr, 0);
    chk("rst_in_cs", input_if.cs, 0);
    chk("rst_in_addr", input_if.addr, 0);
    chk("rst_param_cs", param_if.cs, 0);
    chk("rst_param_addr", param_if.addr, 0);
  endtask

  // Reference: output pixel (ch, oy, ox) copies input pixel (ch, oy/S, ox/S).
  task automatic build_model(input int r, input int c, input int s_raw);
    int s;
    s = (s_raw == 0) ? 1 : ((s_raw > 4) ? 4 : s_raw);
    exp_q.delete();
    for (int ch = 0; ch < c; ch++)
      for (int oy = 0; oy < r * s; oy++)
        for (int ox = 0; ox < r * s; ox++)
          exp_q.push_back(int'(in_mem[ch * r * r + (oy / s) * r + (ox / s)]));
    n_exp   = exp_q.size();
    fin_rel = (r == 0 || c == 0) ? 4 : n_exp + 5;
  endtask

  task automatic run(input string nm, input int r, input int c, input int s_raw,
                     input int lat_lit, input int n_lit, input int abort_at);
    pmem[0] = r;
    pmem[1] = c;
    pmem[2] = s_raw;
    pmem[3] = 0;
    build_model(r, c, s_raw);
    for (int i = 0; i < 1024; i++) out_mem[i] = -1;
    wcount  = 0;
    fin_lat = -1;
    done    = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    rel    = -1;
    active = 1;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #2;
      active = 0;
      rstn   = 1'b0;
      #1;
      check_reset();
      @(negedge clk);
      rstn = 1'b1;
      return;
    end
    for (int i = 0; i < n_exp + 40; i++) begin
      @(posedge clk);
      if (done) break;
    end
    if (!done) begin
      active = 0;
      chk({nm, "_timeout"}, 0, 1);
    end
    chk({nm, "_writes"}, wcount, n_lit);
    chk({nm, "_latency"}, fin_lat, lat_lit);
  endtask

  int lit1[16] = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};

  initial begin
    logic exp_w;
    total  = 0;
    bad    = 0;
    active = 0;
    done   = 0;
    rel    = 0;
    start  = 1'b0;
    rstn   = 1'b0;
    for (int i = 0; i < 256; i++) in_mem[i] = 8'h0;

    fork
      forever begin
        @(negedge clk);
        if (active) begin
          rel++;
          exp_w = (rel >= 5) && (rel < 5 + n_exp);
          chk("w_req", output_if.W_req, exp_w);
          if (exp_w) begin
            chk("w_addr", output_if.addr, rel - 5);
            chk("w_data", output_if.W_data, exp_q[rel - 5]);
          end
          if (output_if.W_req === 1'b1) begin
            wcount++;
            if (output_if.addr < 1024) out_mem[output_if.addr] = int'(output_if.W_data[7:0]);
          end
          chk("finish", finish, (rel == fin_rel) ? 1 : 0);
          if (finish === 1'b1) fin_lat = rel + 1;
          if (rel >= fin_rel + 1) begin
            active = 0;
            done   = 1;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check_reset();
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // R=2 C=1 S=2
    for (int i = 0; i < 4; i++) in_mem[i] = 8'(i + 1);
    run("s2x2", 2, 1, 2, 22, 16, 0);
    for (int i = 0; i < 16; i++) chk("s2x2_data", out_mem[i], lit1[i]);

    // R=3 C=1 S=1 identity
    for (int i = 0; i < 9; i++) in_mem[i] = 8'(i);
    run("ident", 3, 1, 1, 15, 9, 0);
    for (int i = 0; i < 9; i++) chk("ident_data", out_mem[i], i);

    // R=3 C=2 S=3
    for (int i = 0; i < 9; i++) begin
      in_mem[i]     = 8'(8'h10 + i);
      in_mem[9 + i] = 8'(8'h80 + i);
    end
    run("c2s3", 3, 2, 3, 168, 162, 0);
    chk("c2s3_w81", out_mem[81], 8'h80);
    chk("c2s3_w161", out_mem[161], 8'h88);

    // Scale clamps
    for (int i = 0; i < 4; i++) in_mem[i] = 8'(i + 1);
    run("s0", 2, 1, 0, 10, 4, 0);
    run("s7", 2, 1, 7, 70, 64, 0);
    chk("s7_w63", out_mem[63], 4);

    // Empty layer
    run("c0", 2, 0, 2, 5, 0, 0);

    // Reset mid-RUN, then a clean rerun
    run("abort", 2, 1, 2, 0, 0, 10);
    repeat (2) @(negedge clk);
    run("rerun", 2, 1, 2, 22, 16, 0);
    for (int i = 0; i < 16; i++) chk("rerun_data", out_mem[i], lit1[i]);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
